// File: rtl/display_mux_n_if.sv
// Bus between SoC display registers and the multiplexed 7-segment scanner.
// Master drives the display request; slave (the scanner) returns pin-level outputs.
interface display_mux_n_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   data;
  logic [NUM_DIGITS-1:0]     dp;
  logic [NUM_DIGITS-1:0]     blank;
  logic [3:0]                brightness;
  logic [NUM_DIGITS-1:0]     anode;
  logic [7:0]                cathode;
  logic                      frame_tick;

  modport master (
    output enable, data, dp, blank, brightness,
    input  anode, cathode, frame_tick
  );

  modport slave (
    input  enable, data, dp, blank, brightness,
    output anode, cathode, frame_tick
  );
endinterface

// File: rtl/display_mux_n.sv
// Multiplexed common-anode 7-segment scanner: hex decode, dp/blank, 4-bit PWM, frame shadowing.
// Optional leading-zero suppression when DISPLAY_MUX_LEADING_ZERO_BLANK_EN is defined.
module display_mux_n #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned REFRESH_COUNT = 100000
) (
  input logic            clk,
  input logic            reset,
  display_mux_n_if.slave bus
);

  localparam int unsigned CntW = $clog2(REFRESH_COUNT);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CntW-1:0]         cnt_q;
  logic [3:0]              pwm_q;
  logic [IdxW-1:0]         idx_q;
  logic [4*NUM_DIGITS-1:0] sh_data_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q;
  logic [NUM_DIGITS-1:0]   sh_blank_q;
  logic [NUM_DIGITS-1:0]   anode_q;
  logic [7:0]              cathode_q;
  logic                    frame_tick_q;

  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    sel_sup;
  logic                    lit;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic [7:0]              cathode_d;

  // Segments {G,F,E,D,C,B,A}, active low.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] suppress;

  // Digit i>0 goes dark when it and every higher digit is zero with no dp set.
  always_comb begin
    suppress = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      suppress[i] = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (j >= i && (sh_data_q[4*j +: 4] != 4'h0 || sh_dp_q[j])) begin
          suppress[i] = 1'b0;
        end
      end
    end
  end
`endif

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_sup   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_nib   = sh_data_q[4*i +: 4];
        sel_dp    = sh_dp_q[i];
        sel_blank = sh_blank_q[i];
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
        sel_sup   = suppress[i];
`endif
      end
    end
  end

  always_comb begin
    lit       = bus.enable && !sel_blank && !sel_sup && (pwm_q < bus.brightness);
    seg       = decode(sel_nib);
    cathode_d = lit ? {~sel_dp, seg} : 8'hFF;
    anode_d   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && idx_q == IdxW'(i)) begin
        anode_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      pwm_q        <= 4'h0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      anode_q      <= '1;
      cathode_q    <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else if (!bus.enable) begin
      // Held at zero so re-enable starts at digit 0 with a full slot.
      cnt_q        <= '0;
      pwm_q        <= 4'h0;
      idx_q        <= '0;
      anode_q      <= '1;
      cathode_q    <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      pwm_q        <= pwm_q + 4'h1;
      frame_tick_q <= 1'b0;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      if (cnt_q == CntW'(REFRESH_COUNT - 1)) begin
        cnt_q <= '0;
        if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
          idx_q        <= '0;
          frame_tick_q <= 1'b1;
          sh_data_q    <= bus.data;
          sh_dp_q      <= bus.dp;
          sh_blank_q   <= bus.blank;
        end else begin
          idx_q <= idx_q + IdxW'(1);
        end
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign bus.anode      = anode_q;
  assign bus.cathode    = cathode_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_mux_n.sv
// Self-checking bench for display_mux_n (NUM_DIGITS=4, REFRESH_COUNT=32).
module tb_display_mux_n;
  localparam int unsigned N     = 4;
  localparam int unsigned RC    = 32;
  localparam int unsigned FRAME = N * RC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  display_mux_n_if #(.NUM_DIGITS(N)) ifc ();

  display_mux_n #(.NUM_DIGITS(N), .REFRESH_COUNT(RC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] seg_of(input logic [3:0] nib);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[nib];
  endfunction

  function automatic logic [3:0] sel_of(input int d);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
    return a;
  endfunction

  // Reference: t counts enabled cycles since reset/enable; digit and PWM phase follow from t.
  function automatic logic [11:0] model_out(input int t, input logic [15:0] sd,
                                            input logic [3:0] sdp, input logic [3:0] sbl,
                                            input logic [3:0] br);
    int d;
    int pwm;
    logic on;
    logic [7:0] c;
    d   = (t / RC) % N;
    pwm = t % 16;
    on  = !sbl[d] && (pwm < int'(br));
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      logic all0;
      all0 = 1'b1;
      for (int j = d; j < N; j++) if (sd[4*j +: 4] != 4'h0 || sdp[j]) all0 = 1'b0;
      if (all0) on = 1'b0;
    end
`endif
    c = seg_of(sd[4*d +: 4]);
    c[7] = ~sdp[d];
    return on ? {sel_of(d), c} : {4'hF, 8'hFF};
  endfunction

  int          m_t;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_blank;
  logic [3:0]  exp_an;
  logic [7:0]  exp_ca;
  logic        exp_ft;

  always @(posedge clk) begin
    if (reset) begin
      m_t <= 0; m_data <= '0; m_dp <= '0; m_blank <= '0;
      exp_an <= 4'hF; exp_ca <= 8'hFF; exp_ft <= 1'b0;
    end else if (!ifc.enable) begin
      m_t <= 0; exp_an <= 4'hF; exp_ca <= 8'hFF; exp_ft <= 1'b0;
    end else begin
      {exp_an, exp_ca} <= model_out(m_t, m_data, m_dp, m_blank, ifc.brightness);
      m_t    <= m_t + 1;
      exp_ft <= ((m_t + 1) % FRAME) == 0;
      if (((m_t + 1) % FRAME) == 0) begin
        m_data <= ifc.data; m_dp <= ifc.dp; m_blank <= ifc.blank;
      end
    end
  end

  task automatic wait_tick();
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (ifc.frame_tick === 1'b1) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wait_tick: frame_tick not seen within 400 cycles, required a pulse");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.enable = 1'b1; ifc.data = 16'h1234; ifc.dp = '0; ifc.blank = '0; ifc.brightness = 4'd15;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.anode !== 4'hF || ifc.cathode !== 8'hFF || ifc.frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc %0d: got %h/%h/%b, required F/FF/0", i, ifc.anode,
                 ifc.cathode, ifc.frame_tick);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [7:0] want [4];
    int lit [4];
    want = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    lit = '{0, 0, 0, 0};
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      checks++;
      if (ifc.frame_tick !== (k == FRAME)) begin
        errors++;
        $display("FAIL first_frame tick k=%0d: got %b, required %b", k, ifc.frame_tick, k == FRAME);
      end
      checks++;
      if (ifc.anode !== 4'hF && ifc.cathode !== 8'hC0) begin
        errors++;
        $display("FAIL first_frame cathode k=%0d: got %h, required C0", k, ifc.cathode);
      end
    end
    for (int k = 1; k <= FRAME; k++) begin
      int d;
      @(negedge clk);
      d = (k - 1) / RC;
      checks++;
      if (ifc.frame_tick !== (k == FRAME)) begin
        errors++;
        $display("FAIL tick_period k=%0d: got %b, required %b", k, ifc.frame_tick, k == FRAME);
      end
      if (ifc.anode !== 4'hF) begin
        lit[d]++;
        checks++;
        if (ifc.anode !== sel_of(d) || ifc.cathode !== want[d]) begin
          errors++;
          $display("FAIL scan k=%0d: got %b/%h, required %b/%h", k, ifc.anode, ifc.cathode,
                   sel_of(d), want[d]);
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      checks++;
      if (lit[d] != 30) begin
        errors++;
        $display("FAIL scan_duty digit %0d: got %0d lit cycles, required 30", d, lit[d]);
      end
    end
  endtask

  task automatic test_pwm();
    int lit [4];
    int dark_bad = 0;
    lit = '{0, 0, 0, 0};
    ifc.brightness = 4'd4; ifc.data = 16'h0008;
    wait_tick();
    for (int k = 1; k <= FRAME; k++) begin
      int d;
      @(negedge clk);
      d = (k - 1) / RC;
      if (ifc.anode !== 4'hF) begin
        lit[d]++;
        checks++;
        if (ifc.cathode !== (d == 0 ? 8'h80 : 8'hC0)) begin
          errors++;
          $display("FAIL pwm_cathode k=%0d: got %h", k, ifc.cathode);
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      checks++;
      if (lit[d] != 8) begin
        errors++;
        $display("FAIL pwm4 digit %0d: got %0d lit cycles, required 8", d, lit[d]);
      end
    end
    ifc.brightness = 4'd0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (ifc.anode !== 4'hF) dark_bad++;
    end
    checks++;
    if (dark_bad != 0) begin
      errors++;
      $display("FAIL pwm0: got %0d lit cycles, required 0", dark_bad);
    end
    ifc.brightness = 4'd15;
  endtask

  task automatic test_shadow();
    logic [7:0] old_w [4];
    logic [7:0] new_w [4];
    old_w = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    new_w = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    ifc.data = 16'h1234;
    wait_tick();
    for (int f = 0; f < 2; f++) begin
      for (int k = 1; k <= FRAME; k++) begin
        int d;
        @(negedge clk);
        d = (k - 1) / RC;
        if (ifc.anode !== 4'hF) begin
          checks++;
          if (ifc.cathode !== (f == 0 ? old_w[d] : new_w[d])) begin
            errors++;
            $display("FAIL shadow f=%0d k=%0d: got %h, required %h", f, k, ifc.cathode,
                     f == 0 ? old_w[d] : new_w[d]);
          end
        end
        if (f == 0 && k == 40) ifc.data = 16'hABCD;
      end
    end
  endtask

  task automatic test_dp_blank();
    ifc.data = 16'h1234; ifc.dp = 4'b0001; ifc.blank = 4'b0100;
    wait_tick();
    for (int k = 1; k <= FRAME; k++) begin
      int d;
      @(negedge clk);
      d = (k - 1) / RC;
      if (d == 2) begin
        checks++;
        if (ifc.anode !== 4'hF || ifc.cathode !== 8'hFF) begin
          errors++;
          $display("FAIL blank k=%0d: got %b/%h, required 1111/FF", k, ifc.anode, ifc.cathode);
        end
      end else if (d == 0 && ifc.anode !== 4'hF) begin
        checks++;
        if (ifc.cathode !== 8'h19) begin
          errors++;
          $display("FAIL dp k=%0d: got %h, required 19", k, ifc.cathode);
        end
      end
    end
    ifc.dp = '0; ifc.blank = '0;
    wait_tick();
  endtask

  task automatic test_enable();
    int lit = 0;
    for (int k = 1; k <= 70; k++) @(negedge clk);
    ifc.enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.anode !== 4'hF || ifc.cathode !== 8'hFF || ifc.frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL disable cyc %0d: got %b/%h/%b, required 1111/FF/0", i, ifc.anode,
                 ifc.cathode, ifc.frame_tick);
      end
    end
    ifc.enable = 1'b1;
    for (int k = 1; k <= RC + 1; k++) begin
      @(negedge clk);
      if (k <= RC) begin
        if (ifc.anode === 4'hE) lit++;
        checks++;
        if (ifc.anode !== 4'hF && ifc.anode !== 4'hE) begin
          errors++;
          $display("FAIL reenable k=%0d: got %b, required 1110 or 1111", k, ifc.anode);
        end
        if (k == 1) begin
          checks++;
          if (ifc.cathode !== 8'h99) begin
            errors++;
            $display("FAIL reenable_first: got %h, required 99", ifc.cathode);
          end
        end
      end else begin
        checks++;
        if (ifc.anode !== 4'hD) begin
          errors++;
          $display("FAIL reenable_slot_end: got %b, required 1101", ifc.anode);
        end
      end
    end
    checks++;
    if (lit != 30) begin
      errors++;
      $display("FAIL reenable_slot: got %0d lit cycles, required 30", lit);
    end
  endtask

`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero();
    logic [15:0] pd [3];
    logic [3:0]  pdp [3];
    logic [3:0]  on [3];
    pd = '{16'h0045, 16'h0000, 16'h0045};
    pdp = '{4'b0000, 4'b0000, 4'b1000};
    on = '{4'b0011, 4'b0001, 4'b1111};
    for (int p = 0; p < 3; p++) begin
      int lit [4];
      lit = '{0, 0, 0, 0};
      ifc.data = pd[p]; ifc.dp = pdp[p];
      wait_tick();
      for (int k = 1; k <= FRAME; k++) begin
        @(negedge clk);
        if (ifc.anode !== 4'hF) lit[(k - 1) / RC]++;
      end
      for (int d = 0; d < N; d++) begin
        checks++;
        if (lit[d] != (on[p][d] ? 30 : 0)) begin
          errors++;
          $display("FAIL lzb pat %0d digit %0d: got %0d lit cycles, required %0d", p, d, lit[d],
                   on[p][d] ? 30 : 0);
        end
      end
    end
    ifc.dp = '0;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (ifc.anode !== exp_an || ifc.cathode !== exp_ca || ifc.frame_tick !== exp_ft) begin
        errors++;
        $display("FAIL random cyc %0d: got %b/%h/%b, required %b/%h/%b", c, ifc.anode,
                 ifc.cathode, ifc.frame_tick, exp_an, exp_ca, exp_ft);
      end
      case ($urandom_range(0, 15))
        0: ifc.data = 16'($urandom);
        1: ifc.dp = 4'($urandom);
        2: ifc.blank = 4'($urandom);
        3: ifc.brightness = 4'($urandom);
        4: ifc.data = {8'h00, 8'($urandom)};
        default: ;
      endcase
      if ($urandom_range(0, 299) == 0) ifc.enable = ~ifc.enable;
      reset = ($urandom_range(0, 799) == 0);
    end
    reset = 1'b0;
    ifc.enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pwm();
    test_shadow();
    test_dp_blank();
    test_enable();
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
